// File: rtl/fp_mul_unit_if.sv
// Operand/result bundle between the FP register file ports and the multiplier.
interface fp_mul_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        invalid;

    modport master (
        output start, op_a, op_b,
        input  busy, done, result, overflow, underflow, invalid
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, result, overflow, underflow, invalid
    );
endinterface

// File: rtl/fp_mul_unit.sv
// Iterative IEEE-754 single multiply, shift-add mantissa, truncating, flush-to-zero.
// Latency: done pulses 24/BITS_PER_CYCLE+2 cycles after the start-accept edge, fixed.
// Backpressure: none; start is ignored while busy, result held until the next done.
module fp_mul_unit #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic clk,
    input  logic reset,
    fp_mul_if.slave bus
);
    localparam int MUL_CYCLES = 24 / BITS_PER_CYCLE;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, b_q;
    logic [47:0]        mcand_q, acc_q, partial;
    logic [23:0]        mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic signed [9:0]  exp_q, exp_n;
    logic [22:0]        mant_n;
    logic [31:0]        result_q, result_d;
    logic               ovf_q, unf_q, inv_q, ovf_d, unf_d, inv_d;
    logic               sign;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    // Partial product for the multiplier bits retired this cycle.
    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) partial = partial + (mcand_q << i);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = MUL;
            MUL:  if (cnt_q == CNT_W'(MUL_CYCLES)) state_d = NORM;
            NORM: state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sign   = a_q[31] ^ b_q[31];
    assign a_nan  = (&a_q[30:23]) & (|a_q[22:0]);
    assign b_nan  = (&b_q[30:23]) & (|b_q[22:0]);
    assign a_inf  = (&a_q[30:23]) & ~(|a_q[22:0]);
    assign b_inf  = (&b_q[30:23]) & ~(|b_q[22:0]);
    assign a_zero = ~(|a_q[30:23]);
    assign b_zero = ~(|b_q[30:23]);

    assign exp_n  = acc_q[47] ? exp_q + 10'sd1 : exp_q;
    assign mant_n = acc_q[47] ? acc_q[46:24] : acc_q[45:23];

    always_comb begin
        result_d = {sign, exp_n[7:0], mant_n};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        inv_d    = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            result_d = 32'h7FC0_0000;
            inv_d    = 1'b1;
        end else if (a_inf || b_inf) begin
            result_d = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            result_d = {sign, 31'd0};
        end else if (exp_n >= 10'sd255) begin
            result_d = {sign, 8'hFF, 23'd0};
            ovf_d    = 1'b1;
        end else if (exp_n <= 10'sd0) begin
            result_d = {sign, 31'd0};
            unf_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (bus.start) begin
                    a_q   <= bus.op_a;
                    b_q   <= bus.op_b;
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
                    unf_q <= 1'b0;
                    inv_q <= 1'b0;
                end
                MUL: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // First MUL cycle unpacks the latched operands; the rest accumulate.
                    if (cnt_q == '0) begin
                        mcand_q  <= {25'd1, a_q[22:0]};
                        mplier_q <= {1'b1, b_q[22:0]};
                        acc_q    <= '0;
                        exp_q    <= $signed({2'b00, a_q[30:23]} + {2'b00, b_q[30:23]} - 10'd127);
                    end else begin
                        acc_q    <= acc_q + partial;
                        mcand_q  <= mcand_q << BITS_PER_CYCLE;
                        mplier_q <= mplier_q >> BITS_PER_CYCLE;
                    end
                end
                NORM: begin
                    result_q <= result_d;
                    ovf_q    <= ovf_d;
                    unf_q    <= unf_d;
                    inv_q    <= inv_d;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state_q == MUL) || (state_q == NORM);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.invalid   = inv_q;
endmodule

// File: tb/tb_fp_mul_unit.sv
// Scoreboarded random/directed bench for fp_mul_unit at BITS_PER_CYCLE 1 and 8.
module tb_fp_mul_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf, unf, inv;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb1[$];
    exp_t sb8[$];

    fp_mul_if bus1();
    fp_mul_if bus8();

    fp_mul_unit #(.BITS_PER_CYCLE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    fp_mul_unit #(.BITS_PER_CYCLE(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Reference model straight from the IEEE rules: integer mantissa product, truncation, FTZ.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        int ea, eb, e;
        logic s, na, nb, ia, ib, za, zb;
        logic [63:0] p;
        r.res = 32'd0; r.ovf = 1'b0; r.unf = 1'b0; r.inv = 1'b0; r.acc = 0; r.lat = 0;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        za = (ea == 0);
        zb = (eb == 0);
        if (na || nb || (ia && zb) || (ib && za)) begin
            r.res = 32'h7FC0_0000; r.inv = 1'b1;
        end else if (ia || ib) begin
            r.res = {s, 8'hFF, 23'd0};
        end else if (za || zb) begin
            r.res = {s, 31'd0};
        end else begin
            p = ({41'd0, a[22:0]} + 64'h80_0000) * ({41'd0, b[22:0]} + 64'h80_0000);
            e = ea + eb - 127;
            if (p >= 64'h8000_0000_0000) begin
                p = p >> 24; e = e + 1;
            end else begin
                p = p >> 23;
            end
            if (e >= 255) begin
                r.res = {s, 8'hFF, 23'd0}; r.ovf = 1'b1;
            end else if (e <= 0) begin
                r.res = {s, 31'd0}; r.unf = 1'b1;
            end else begin
                r.res = {s, 8'(e), p[22:0]};
            end
        end
        return r;
    endfunction

    function automatic exp_t mk(input logic [31:0] res, input logic [2:0] f);
        exp_t r;
        r.res = res; r.ovf = f[2]; r.unf = f[1]; r.inv = f[0]; r.acc = 0; r.lat = 0;
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            2: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            3: v[30:0] = 31'd0;
            4: v[30:23] = 8'(64 + $urandom_range(0, 127));
            default: ;
        endcase
        return v;
    endfunction

    task automatic issue(input int which, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        @(negedge clk);
        if (which == 1) begin bus1.start = 1'b1; bus1.op_a = a; bus1.op_b = b; end
        else            begin bus8.start = 1'b1; bus8.op_a = a; bus8.op_b = b; end
        @(posedge clk);
        #1;
        e.acc = cyc;
        if (which == 1) begin
            e.lat = 26;
            bus1.start = 1'b0; bus1.op_a = $urandom; bus1.op_b = $urandom;
            sb1.push_back(e);
            chk("busy1_after_accept", 32'(bus1.busy), 32'd1);
        end else begin
            e.lat = 5;
            bus8.start = 1'b0; bus8.op_a = $urandom; bus8.op_b = $urandom;
            sb8.push_back(e);
            chk("busy8_after_accept", 32'(bus8.busy), 32'd1);
        end
    endtask

    task automatic wait_idle(input int which);
        int sz;
        sz = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            sz = (which == 1) ? sb1.size() : sb8.size();
            if (sz == 0) break;
        end
        chk("done_timeout", 32'(sz), 32'd0);
        if (which == 1) sb1.delete(); else sb8.delete();
        @(negedge clk);
    endtask

    task automatic judge(input string tag, input exp_t e, input logic [31:0] res,
                         input logic [2:0] flags, input logic busy);
        chk({tag, "_result"}, res, e.res);
        chk({tag, "_flags"}, 32'(flags), 32'({e.ovf, e.unf, e.inv}));
        chk({tag, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
        chk({tag, "_busy_with_done"}, 32'(busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (bus1.done) begin
            chk("done1_outstanding", 32'(sb1.size() != 0), 32'd1);
            if (sb1.size() != 0)
                judge("dut1", sb1.pop_front(), bus1.result,
                      {bus1.overflow, bus1.underflow, bus1.invalid}, bus1.busy);
        end
    end

    always @(negedge clk) begin
        if (bus8.done) begin
            chk("done8_outstanding", 32'(sb8.size() != 0), 32'd1);
            if (sb8.size() != 0)
                judge("dut8", sb8.pop_front(), bus8.result,
                      {bus8.overflow, bus8.underflow, bus8.invalid}, bus8.busy);
        end
    end

    logic [31:0] dir_a [10] = '{32'h4000_0000, 32'h3FC0_0000, 32'h3F80_0001, 32'hBF80_0000, 32'h0000_0001,
                                32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 32'hFFC1_2345, 32'hFF80_0000};
    logic [31:0] dir_b [10] = '{32'h4040_0000, 32'h3FC0_0000, 32'h3F80_0001, 32'h0000_0000, 32'h3F80_0000,
                                32'h7F00_0000, 32'h0080_0000, 32'h0000_0000, 32'h3F80_0000, 32'h4000_0000};
    logic [31:0] dir_r [10] = '{32'h40C0_0000, 32'h4010_0000, 32'h3F80_0002, 32'h8000_0000, 32'h0000_0000,
                                32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000};
    logic [2:0]  dir_f [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                3'b100, 3'b010, 3'b001, 3'b001, 3'b000};

    initial begin
        logic [31:0] a, b;
        bus1.start = 1'b0; bus1.op_a = '0; bus1.op_b = '0;
        bus8.start = 1'b0; bus8.op_a = '0; bus8.op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(bus1.busy), 32'd0);
        chk("reset_done", 32'(bus1.done), 32'd0);
        chk("reset_result", bus1.result, 32'd0);
        chk("reset_flags", 32'({bus1.overflow, bus1.underflow, bus1.invalid}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            issue(1, dir_a[i], dir_b[i], mk(dir_r[i], dir_f[i]));
            wait_idle(1);
        end

        // A start pulse mid-operation must be ignored and must not disturb the result.
        issue(1, 32'h4000_0000, 32'h4040_0000, mk(32'h40C0_0000, 3'b000));
        repeat (4) @(negedge clk);
        bus1.start = 1'b1; bus1.op_a = 32'h3FC0_0000; bus1.op_b = 32'hC120_0000;
        @(negedge clk);
        bus1.start = 1'b0;
        wait_idle(1);

        // Reset in the middle of an operation: outputs clear at once and no done follows.
        issue(1, 32'h4000_0000, 32'h4040_0000, mk(32'h40C0_0000, 3'b000));
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_busy", 32'(bus1.busy), 32'd0);
        chk("midreset_result", bus1.result, 32'd0);
        sb1.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(1, 32'h3FC0_0000, 32'h3FC0_0000, mk(32'h4010_0000, 3'b000));
        wait_idle(1);

        for (int i = 0; i < 30; i++) begin
            a = rand_op();
            b = rand_op();
            issue(1, a, b, model(a, b));
            wait_idle(1);
        end

        issue(8, 32'h4000_0000, 32'h4040_0000, mk(32'h40C0_0000, 3'b000));
        wait_idle(8);
        for (int i = 0; i < 20; i++) begin
            a = rand_op();
            b = rand_op();
            issue(8, a, b, model(a, b));
            wait_idle(8);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_mul_unit.md
Name: fp_mul_unit

Overview:
Iterative IEEE-754 single-precision multiplier fed directly from the floating-point register file read ports (busA/busB). It takes two operands on a start pulse and computes the product over several cycles with a shift-add mantissa datapath. It returns a 32-bit result with a one-cycle done pulse for write-back into the FP register file (busW/regWr path). Denormals are flushed to zero and rounding is truncation (round toward zero).

Parameters:
BITS_PER_CYCLE, 1, multiplier bits retired per MUL cycle; legal values 1,2,3,4,6,8,12,24; MUL phase lasts 24/BITS_PER_CYCLE cycles

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
opA  input  32  operand A (from FP register file busA)
opB  input  32  operand B (from FP register file busB)
busy  output  1  high from the edge that accepts start until the edge that raises done
done  output  1  one-cycle pulse; result valid from this cycle onward
result  output  32  product; held until the next done
overflow  output  1  sticky until next accepted start; finite inputs gave exponent >= 255
underflow  output  1  sticky until next accepted start; nonzero finite inputs gave exponent <= 0
invalid  output  1  sticky until next accepted start; NaN operand or Inf*0

Behaviour:
- Reset (async, any state): state=IDLE; busy=0; done=0; result=0x00000000; all flags=0; internal accumulators cleared. No done pulse is produced for an operation interrupted by reset.
- FSM: IDLE -> MUL -> NORM -> DONE -> IDLE.
  - IDLE: on start=1, latch opA/opB, clear flags, busy=1, go to MUL. start=0: remain.
  - MUL: 24/BITS_PER_CYCLE cycles; each cycle adds (mantA<<shift) for BITS_PER_CYCLE bits of mantB into a 48-bit accumulator. mant = {1'b1, frac} for normal inputs.
  - NORM: one cycle; normalize, compute exponent, apply special cases, load result and flags.
  - DONE: done=1 for exactly this cycle, busy=0; unconditionally return to IDLE.
- Latency: start sampled at edge N. done is high in the cycle after edge N+24/BITS_PER_CYCLE+2 (default: after edge N+26). Latency is fixed and applies to special cases too.
- start while busy (MUL/NORM/DONE): ignored. Latched operands are unaffected by opA/opB changes after acceptance. A new start is accepted no earlier than the cycle after done.
- Sign = signA XOR signB for all results, including zero and Inf. NaN results are always canonical 0x7FC00000.
- Exponent arithmetic: 10-bit signed, e = expA + expB − 127.
  - If product bit 47 = 1: mantissa = P[46:24], e = e+1.
  - Otherwise: mantissa = P[45:23].
  - Lower bits are discarded (truncation).
- Special cases (precedence order):
  1. Either operand NaN (exp=255, frac≠0) -> 0x7FC00000, invalid=1.
  2. Inf × zero, either order -> 0x7FC00000, invalid=1.
  3. Either operand Inf -> signed Inf (exp 255, frac 0); no overflow flag.
  4. Either operand zero or denormal (exp=0) -> signed zero; no underflow flag.
  5. Normalized e >= 255 -> signed Inf, overflow=1.
  6. Normalized e <= 0 -> signed zero, underflow=1.
- Flags and result change only in NORM, or on reset, or flags clear on an accepted start. done never asserts outside DONE. busy and done are never high together.

Test Plan:
- Reset, then start with opA=0x40000000 (2.0), opB=0x40400000 (3.0) -> busy high for 26 cycles; done one-cycle pulse after edge N+26; result=0x40C00000; flags 000.
- opA=0x3FC00000 (1.5), opB=0x3FC00000 -> normalization shift path; result=0x40100000 (2.25). Also opA=0x3F800001, opB=0x3F800001 -> truncation check; result=0x3F800002.
- opA=0xBF800000 (−1.0), opB=0x00000000 -> result=0x80000000. opA=0x00000001 (denormal), opB=0x3F800000 -> result=0x00000000; underflow=0.
- opA=opB=0x7F000000 -> result=0x7F800000, overflow=1. opA=opB=0x00800000 -> result=0x00000000, underflow=1.
- opA=0x7F800000, opB=0x00000000 -> 0x7FC00000, invalid=1. opA=0xFFC12345 (NaN), opB=0x3F800000 -> 0x7FC00000, invalid=1. opA=0xFF800000, opB=0x40000000 -> 0xFF800000, flags 000.
- Start 2.0×3.0, pulse start again at cycle 5 with different operands -> ignored; result=0x40C00000. Start again, assert reset at cycle 10 -> busy=0 and result=0 immediately; no done pulse. Next start is accepted normally. Repeat the first test with BITS_PER_CYCLE=8 -> done after edge N+5.
